// File: rtl/dut_emu_pkg.sv
// Shared types and default sizing for the config-chain emulator.
// FSM encoding plus the parameter defaults used by the top level and the bench.
package dut_emu_pkg;

    typedef enum logic [1:0] {
        RST_HELD = 2'd0,
        IDLE     = 2'd1,
        SHIFTING = 2'd2,
        LOADED   = 2'd3
    } emu_state_t;

    localparam int unsigned CHAIN_LEN_DEF   = 64;
    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned CNT_W_DEF       = 16;

endpackage

// File: rtl/dut_cfg_chain_emu_if.sv
// FW-facing config-chain bus: serial clock/data, load strobe, chain reset, bank select, return data.
// The master modport is the FW side; the slave modport is the emulator side.
interface dut_cfg_chain_emu_if;

    logic fw_config_clk;
    logic fw_config_in;
    logic fw_config_load;
    logic fw_reset_not;
    logic fw_super_pixel_sel;
    logic fw_config_out;

    modport master (
        output fw_config_clk,
        output fw_config_in,
        output fw_config_load,
        output fw_reset_not,
        output fw_super_pixel_sel,
        input  fw_config_out
    );

    modport slave (
        input  fw_config_clk,
        input  fw_config_in,
        input  fw_config_load,
        input  fw_reset_not,
        input  fw_super_pixel_sel,
        output fw_config_out
    );

endinterface

// File: rtl/dut_cfg_chain_emu_sync_edge_det.sv
// Multi-flop synchroniser for one asynchronous FW input with rise/fall pulse detection.
// Reset parks every flop at IDLE_VAL so no spurious edge appears when reset releases.
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        IDLE_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{IDLE_VAL}};
            prev   <= IDLE_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev   <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/dut_cfg_chain_emu.sv
// Emulates the ASIC configuration shift register: serial shift-in, MSB return, and
// capture into one of two shadow banks on a load strobe, all oversampled in the fw_clk domain.
module dut_cfg_chain_emu
    import dut_emu_pkg::*;
#(
    parameter int unsigned CHAIN_LEN   = CHAIN_LEN_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic                 fw_clk,
    input  logic                 fw_rst,
    dut_cfg_chain_emu_if.slave   fw,
    output logic [CHAIN_LEN-1:0] cfg_bank0,
    output logic [CHAIN_LEN-1:0] cfg_bank1,
    output logic [CNT_W-1:0]     shift_count,
    output logic [CNT_W-1:0]     load_count,
    output logic                 chain_overrun,
    output logic [1:0]           emu_state
);

    localparam logic [CNT_W:0] OVR_AT = (CNT_W+1)'(CHAIN_LEN + 1);

    logic cclk_lvl, clk_rise, cclk_fall;
    logic in_lvl, in_rise, in_fall;
    logic load_lvl, load_rise, load_fall;
    logic rstn_lvl, rstn_rise, rstn_fall;
    logic sel_lvl, sel_rise, sel_fall;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_clk (
        .clk(fw_clk), .rst(fw_rst), .din(fw.fw_config_clk),
        .level(cclk_lvl), .rise(clk_rise), .fall(cclk_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_in (
        .clk(fw_clk), .rst(fw_rst), .din(fw.fw_config_in),
        .level(in_lvl), .rise(in_rise), .fall(in_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_load (
        .clk(fw_clk), .rst(fw_rst), .din(fw.fw_config_load),
        .level(load_lvl), .rise(load_rise), .fall(load_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_rstn (
        .clk(fw_clk), .rst(fw_rst), .din(fw.fw_reset_not),
        .level(rstn_lvl), .rise(rstn_rise), .fall(rstn_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_sel (
        .clk(fw_clk), .rst(fw_rst), .din(fw.fw_super_pixel_sel),
        .level(sel_lvl), .rise(sel_rise), .fall(sel_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{cclk_lvl, cclk_fall, in_rise, in_fall, load_lvl, load_rise,
                           rstn_rise, rstn_fall, sel_rise, sel_fall};

    emu_state_t             state, state_nxt;
    logic [CHAIN_LEN-1:0]   chain, chain_nxt;
    logic [CHAIN_LEN-1:0]   bank0_nxt, bank1_nxt;
    logic [CNT_W-1:0]       shift_nxt, load_nxt, shift_inc;
    logic                   ovr_nxt;

    always_ff @(posedge fw_clk or posedge fw_rst) begin
        if (fw_rst) begin
            state <= RST_HELD;
        end else begin
            state <= state_nxt;
        end
    end

    // A same-cycle load and shift: the bank captures the pre-shift chain, then the
    // shift is counted as the first bit after that load.
    always_comb begin
        state_nxt = state;
        chain_nxt = chain;
        bank0_nxt = cfg_bank0;
        bank1_nxt = cfg_bank1;
        shift_nxt = shift_count;
        load_nxt  = load_count;
        ovr_nxt   = chain_overrun;
        shift_inc = (shift_count == '1) ? shift_count : shift_count + CNT_W'(1);

        if (!rstn_lvl) begin
            state_nxt = RST_HELD;
            chain_nxt = '0;
            shift_nxt = '0;
            ovr_nxt   = 1'b0;
        end else if (state == RST_HELD) begin
            state_nxt = IDLE;
        end else begin
            if (load_fall) begin
                if (sel_lvl) begin
                    bank1_nxt = chain;
                end else begin
                    bank0_nxt = chain;
                end
                load_nxt  = load_count + CNT_W'(1);
                shift_nxt = '0;
                ovr_nxt   = 1'b0;
                shift_inc = CNT_W'(1);
                state_nxt = LOADED;
            end
            if (clk_rise) begin
                chain_nxt = {chain[CHAIN_LEN-2:0], in_lvl};
                shift_nxt = shift_inc;
                ovr_nxt   = ovr_nxt | ({1'b0, shift_inc} == OVR_AT);
                state_nxt = SHIFTING;
            end
        end
    end

    always_ff @(posedge fw_clk or posedge fw_rst) begin
        if (fw_rst) begin
            chain         <= '0;
            cfg_bank0     <= '0;
            cfg_bank1     <= '0;
            shift_count   <= '0;
            load_count    <= '0;
            chain_overrun <= 1'b0;
        end else begin
            chain         <= chain_nxt;
            cfg_bank0     <= bank0_nxt;
            cfg_bank1     <= bank1_nxt;
            shift_count   <= shift_nxt;
            load_count    <= load_nxt;
            chain_overrun <= ovr_nxt;
        end
    end

    assign fw.fw_config_out = chain[CHAIN_LEN-1];
    assign emu_state        = state;

endmodule

// File: tb/tb_dut_cfg_chain_emu.sv
// Directed bench for dut_cfg_chain_emu: FW-side serial protocol driven through the interface,
// expected values hand-computed from the shifted patterns.
module tb_dut_cfg_chain_emu;
    import dut_emu_pkg::*;

    localparam int unsigned CL   = 64;
    localparam int unsigned SS   = 2;
    localparam int unsigned CW   = 16;
    localparam int          HOLD = SS + 2;

    logic          fw_clk = 1'b0;
    logic          fw_rst;
    logic [CL-1:0] cfg_bank0, cfg_bank1;
    logic [CW-1:0] shift_count, load_count;
    logic          chain_overrun;
    logic [1:0]    emu_state;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [63:0] pat;
    logic [63:0] exp_bit;

    dut_cfg_chain_emu_if fw_if ();

    dut_cfg_chain_emu #(.CHAIN_LEN(CL), .SYNC_STAGES(SS), .CNT_W(CW)) u_dut (
        .fw_clk        (fw_clk),
        .fw_rst        (fw_rst),
        .fw            (fw_if),
        .cfg_bank0     (cfg_bank0),
        .cfg_bank1     (cfg_bank1),
        .shift_count   (shift_count),
        .load_count    (load_count),
        .chain_overrun (chain_overrun),
        .emu_state     (emu_state)
    );

    always #5 fw_clk = ~fw_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge fw_clk);
    endtask

    task automatic shift_bit(input logic b);
        fw_if.fw_config_in  = b;
        fw_if.fw_config_clk = 1'b0;
        idle(HOLD);
        fw_if.fw_config_clk = 1'b1;
        idle(HOLD);
    endtask

    task automatic load_pulse(input logic sel);
        fw_if.fw_super_pixel_sel = sel;
        idle(HOLD);
        fw_if.fw_config_load = 1'b0;
        idle(HOLD);
        fw_if.fw_config_load = 1'b1;
        idle(HOLD);
    endtask

    initial begin
        pat = 64'hA5A5_0F0F_1234_5678;
        fw_rst                   = 1'b1;
        fw_if.fw_config_clk      = 1'b0;
        fw_if.fw_config_in       = 1'b0;
        fw_if.fw_config_load     = 1'b1;
        fw_if.fw_reset_not       = 1'b1;
        fw_if.fw_super_pixel_sel = 1'b0;
        idle(3);

        check("rst_state", 64'(emu_state), 64'(RST_HELD));
        check("rst_bank0", cfg_bank0, 64'd0);
        check("rst_bank1", cfg_bank1, 64'd0);
        check("rst_shift_cnt", 64'(shift_count), 64'd0);
        check("rst_load_cnt", 64'(load_count), 64'd0);
        check("rst_overrun", 64'(chain_overrun), 64'd0);
        check("rst_out", 64'(fw_if.fw_config_out), 64'd0);

        fw_rst = 1'b0;
        idle(HOLD);
        check("idle_state", 64'(emu_state), 64'(IDLE));

        // pattern into bank0
        for (int i = 63; i >= 0; i--) shift_bit(pat[i]);
        check("p0_shift_cnt", 64'(shift_count), 64'd64);
        check("p0_overrun", 64'(chain_overrun), 64'd0);
        check("p0_out_msb", 64'(fw_if.fw_config_out), 64'd1);
        check("p0_state", 64'(emu_state), 64'(SHIFTING));
        load_pulse(1'b0);
        check("p0_bank0", cfg_bank0, 64'hA5A5_0F0F_1234_5678);
        check("p0_bank1", cfg_bank1, 64'd0);
        check("p0_load_cnt", 64'(load_count), 64'd1);
        check("p0_shift_clr", 64'(shift_count), 64'd0);
        check("p0_state_ld", 64'(emu_state), 64'(LOADED));

        // pattern into bank1, then replay through fw_config_out
        for (int i = 63; i >= 0; i--) shift_bit(pat[i]);
        load_pulse(1'b1);
        check("p1_bank1", cfg_bank1, 64'hA5A5_0F0F_1234_5678);
        check("p1_bank0", cfg_bank0, 64'hA5A5_0F0F_1234_5678);
        check("p1_load_cnt", 64'(load_count), 64'd2);
        check("replay_0", 64'(fw_if.fw_config_out), 64'd1);
        for (int k = 1; k <= 64; k++) begin
            shift_bit(1'b0);
            exp_bit = (k < 64) ? 64'(pat[63-k]) : 64'd0;
            check("replay", 64'(fw_if.fw_config_out), exp_bit);
        end
        check("replay_state", 64'(emu_state), 64'(SHIFTING));
        check("replay_bank1", cfg_bank1, 64'hA5A5_0F0F_1234_5678);

        // overrun: chain is all zeros here, so this load zeroes bank0
        load_pulse(1'b0);
        check("ov_bank0_zero", cfg_bank0, 64'd0);
        for (int i = 0; i < 64; i++) shift_bit(1'b1);
        check("ov_cnt64", 64'(shift_count), 64'd64);
        check("ov_not_yet", 64'(chain_overrun), 64'd0);
        shift_bit(1'b1);
        check("ov_cnt65", 64'(shift_count), 64'd65);
        check("ov_set", 64'(chain_overrun), 64'd1);
        load_pulse(1'b1);
        check("ov_clr", 64'(chain_overrun), 64'd0);
        check("ov_cnt_clr", 64'(shift_count), 64'd0);
        check("ov_bank1", cfg_bank1, 64'hFFFF_FFFF_FFFF_FFFF);
        check("ov_load_cnt", 64'(load_count), 64'd4);

        // chain reset mid-shift
        for (int i = 0; i < 10; i++) shift_bit(i[0]);
        check("rn_cnt10", 64'(shift_count), 64'd10);
        check("rn_out_pre", 64'(fw_if.fw_config_out), 64'd1);
        fw_if.fw_reset_not = 1'b0;
        idle(HOLD);
        check("rn_state", 64'(emu_state), 64'(RST_HELD));
        check("rn_cnt", 64'(shift_count), 64'd0);
        check("rn_out", 64'(fw_if.fw_config_out), 64'd0);
        check("rn_bank0", cfg_bank0, 64'd0);
        check("rn_bank1", cfg_bank1, 64'hFFFF_FFFF_FFFF_FFFF);
        check("rn_load_cnt", 64'(load_count), 64'd4);
        shift_bit(1'b1);
        check("rn_shift_ignored", 64'(shift_count), 64'd0);
        fw_if.fw_reset_not = 1'b1;
        idle(HOLD);
        check("rn_idle", 64'(emu_state), 64'(IDLE));

        // simultaneous clk rise and load fall
        shift_bit(1'b1);
        shift_bit(1'b1);
        shift_bit(1'b0);
        check("sim_cnt3", 64'(shift_count), 64'd3);
        fw_if.fw_config_clk      = 1'b0;
        fw_if.fw_config_in       = 1'b1;
        fw_if.fw_super_pixel_sel = 1'b0;
        idle(HOLD);
        fw_if.fw_config_clk  = 1'b1;
        fw_if.fw_config_load = 1'b0;
        idle(HOLD);
        check("sim_bank0", cfg_bank0, 64'h6);
        check("sim_cnt1", 64'(shift_count), 64'd1);
        check("sim_state", 64'(emu_state), 64'(SHIFTING));
        check("sim_load_cnt", 64'(load_count), 64'd5);
        fw_if.fw_config_load = 1'b1;
        fw_if.fw_config_clk  = 1'b0;
        idle(HOLD);
        load_pulse(1'b1);
        check("sim_bank1_post", cfg_bank1, 64'hD);
        check("sim_state_ld", 64'(emu_state), 64'(LOADED));
        check("sim_load_cnt6", 64'(load_count), 64'd6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
